// File: rtl/ext_ram_loader_if.sv
// LLR stream and external RAM write bus seen by ext_ram_loader.
// master = LLR source / RAM observer, slave = the loader itself.
interface ext_ram_loader_if #(
  parameter int unsigned IN_WIDTH   = 8,
  parameter int unsigned LLR_WIDTH  = 6,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic signed [IN_WIDTH-1:0]    llr_in;
  logic                          llr_valid;
  logic                          llr_ready;
  logic [ADDR_WIDTH-1:0]         ram_addr;
  logic [3*LLR_WIDTH-1:0]        ram_data;
  logic                          ram_we;
  logic                          ram_cs;

  modport master (
    output llr_in, llr_valid,
    input  llr_ready, ram_addr, ram_data, ram_we, ram_cs
  );

  modport slave (
    input  llr_in, llr_valid,
    output llr_ready, ram_addr, ram_data, ram_we, ram_cs
  );
endinterface

// File: rtl/ext_ram_loader.sv
// Saturates a stream of channel LLRs to LLR_WIDTH bits, packs three per word
// and writes one NUM_WORDS frame into the external LLR RAM from address 0.
module ext_ram_loader #(
  parameter int unsigned IN_WIDTH   = 8,
  parameter int unsigned LLR_WIDTH  = 6,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_WORDS  = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  ext_ram_loader_if.slave      bus,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned DATA_WIDTH = 3 * LLR_WIDTH;
  localparam int          LLR_MAX    = (1 << (LLR_WIDTH - 1)) - 1;
  localparam int          LLR_MIN    = -(1 << (LLR_WIDTH - 1));
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    LAST = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                    r_state;
  logic [1:0]                r_lane;
  logic [ADDR_WIDTH-1:0]     r_word_cnt;
  logic [2*LLR_WIDTH-1:0]    r_pack;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [DATA_WIDTH-1:0]     r_data;
  logic                      r_cs;
  logic                      r_busy;
  logic                      r_done;

  logic [LLR_WIDTH-1:0]      w_sat;
  logic                      w_hs;

  // Clamp a signed sample into the signed LLR_WIDTH range.
  function automatic logic [LLR_WIDTH-1:0] sat_llr(input logic signed [IN_WIDTH-1:0] x);
    if (int'(x) > LLR_MAX) begin
      sat_llr = {1'b0, {(LLR_WIDTH-1){1'b1}}};
    end else if (int'(x) < LLR_MIN) begin
      sat_llr = {1'b1, {(LLR_WIDTH-1){1'b0}}};
    end else begin
      sat_llr = x[LLR_WIDTH-1:0];
    end
  endfunction

  assign w_sat = sat_llr(bus.llr_in);
  assign w_hs  = bus.llr_valid && (r_state == FILL);

  // Control FSM, lane packing and registered RAM strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_lane     <= 2'd0;
      r_word_cnt <= '0;
      r_pack     <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_cs       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_cs   <= 1'b0;
      r_done <= 1'b0;
      if (abort) begin
        // Any strobe already on the bus this cycle still completes.
        r_state    <= IDLE;
        r_lane     <= 2'd0;
        r_word_cnt <= '0;
        r_pack     <= '0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_state    <= FILL;
              r_lane     <= 2'd0;
              r_word_cnt <= '0;
              r_busy     <= 1'b1;
            end
          end
          FILL: begin
            if (w_hs) begin
              case (r_lane)
                2'd0: begin
                  r_pack[LLR_WIDTH-1:0] <= w_sat;
                  r_lane                <= 2'd1;
                end
                2'd1: begin
                  r_pack[2*LLR_WIDTH-1:LLR_WIDTH] <= w_sat;
                  r_lane                          <= 2'd2;
                end
                default: begin
                  r_data <= {w_sat, r_pack};
                  r_addr <= r_word_cnt;
                  r_cs   <= 1'b1;
                  r_lane <= 2'd0;
                  // Counter parks on the last word so ram_addr never wraps.
                  if (r_word_cnt == LAST_WORD) begin
                    r_state <= LAST;
                  end else begin
                    r_word_cnt <= r_word_cnt + ADDR_WIDTH'(1);
                  end
                end
              endcase
            end
          end
          LAST: begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.llr_ready = (r_state == FILL);
  assign bus.ram_addr  = r_addr;
  assign bus.ram_data  = r_data;
  assign bus.ram_cs    = r_cs;
  assign bus.ram_we    = r_cs;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_ext_ram_loader.sv
// Scoreboard bench for ext_ram_loader: stimulus queues expected RAM writes,
// a negedge monitor pops and compares every strobe.
module tb_ext_ram_loader;
  localparam int unsigned IN_W  = 8;
  localparam int unsigned LLR_W = 6;
  localparam int unsigned AW    = 8;
  localparam int unsigned NW    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy;
  logic done;

  ext_ram_loader_if #(.IN_WIDTH(IN_W), .LLR_WIDTH(LLR_W), .ADDR_WIDTH(AW)) bus ();

  ext_ram_loader #(
    .IN_WIDTH(IN_W), .LLR_WIDTH(LLR_W), .ADDR_WIDTH(AW), .NUM_WORDS(NW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .bus   (bus.slave),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [25:0] exp_q[$];
  logic [25:0] e;
  bit          mon_en     = 1'b0;
  int          lane_m     = 0;
  bit          strobe_due = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: strobe only in the cycle after a word-completing handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      lane_m     = 0;
      strobe_due = 1'b0;
    end else begin
      if (mon_en) begin
        chk("we_eq_cs", 32'(bus.ram_we), 32'(bus.ram_cs));
        chk("strobe_timing", 32'(bus.ram_cs), 32'(strobe_due));
        if (bus.ram_cs) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_strobe: got addr %h data %h want no strobe", bus.ram_addr, bus.ram_data);
          end else begin
            e = exp_q.pop_front();
            chk("ram_addr", 32'(bus.ram_addr), 32'(e[25:18]));
            chk("ram_data", 32'(bus.ram_data), 32'(e[17:0]));
          end
        end
      end
      strobe_due = 1'b0;
      if (abort) begin
        lane_m = 0;
      end else if (start && !busy) begin
        lane_m = 0;
      end else if (bus.llr_valid && bus.llr_ready) begin
        if (lane_m == 2) begin
          lane_m     = 0;
          strobe_due = 1'b1;
        end else begin
          lane_m++;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] v, input int gap);
    bit ok;
    ok = 1'b0;
    bus.llr_in    = v;
    bus.llr_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      ok = bus.llr_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: llr_ready got 0 want 1");
    end
    bus.llr_valid = 1'b0;
    if (gap > 0) cyc(gap);
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("start_ready", 32'(bus.llr_ready), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  task automatic push(input logic [7:0] a, input logic [17:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic tail_check();
    @(negedge clk);
    chk("last_done", 32'(done), 32'd0);
    chk("last_ready", 32'(bus.llr_ready), 32'd0);
    chk("last_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("done_clear", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic push_basic();
    push(8'd0, 18'h03081);
    push(8'd1, 18'h06144);
    push(8'd2, 18'h09207);
    push(8'd3, 18'h0C2CA);
  endtask

  logic [7:0] sat_v [12];
  int         gaps  [12];

  initial begin
    sat_v = '{8'd100, 8'h9C, 8'hFB, 8'hE0, 8'd31, 8'd0,
              8'hDF, 8'd32, 8'hFF, 8'h7F, 8'h80, 8'd5};
    gaps  = '{1, 0, 2, 0, 0, 3, 1, 0, 0, 2, 1, 0};
    bus.llr_in    = '0;
    bus.llr_valid = 1'b0;

    // Reset behaviour, including llr_valid pulses while held and after release.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.llr_ready), 32'd0);
    chk("rst_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_data", 32'(bus.ram_data), 32'd0);
    chk("rst_we", 32'(bus.ram_we), 32'd0);
    chk("rst_cs", 32'(bus.ram_cs), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    bus.llr_valid = 1'b1;
    cyc(2);
    bus.llr_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;
    bus.llr_valid = 1'b1;
    cyc(4);
    bus.llr_valid = 1'b0;
    chk("idle_ready", 32'(bus.llr_ready), 32'd0);
    chk("idle_busy0", 32'(busy), 32'd0);

    // Basic frame, LLRs 1..12 back-to-back.
    do_start();
    push_basic();
    for (int i = 1; i <= 12; i++) send(8'(i), 0);
    tail_check();

    // Saturation frame.
    cyc(1);
    do_start();
    push(8'd0, 18'h3B81F);
    push(8'd1, 18'h007E0);
    push(8'd2, 18'h3F7E0);
    push(8'd3, 18'h0581F);
    for (int i = 0; i < 12; i++) send(sat_v[i], 0);
    tail_check();

    // Backpressure: llr_valid gaps, same writes.
    cyc(1);
    do_start();
    push_basic();
    for (int i = 1; i <= 12; i++) send(8'(i), gaps[i-1]);
    tail_check();

    // Abort with lane 2 of word 1 being offered in the abort cycle.
    cyc(1);
    do_start();
    push(8'd0, 18'h03081);
    for (int i = 1; i <= 5; i++) send(8'(i), 0);
    abort         = 1'b1;
    bus.llr_in    = 8'd6;
    bus.llr_valid = 1'b1;
    cyc(1);
    abort         = 1'b0;
    bus.llr_valid = 1'b0;
    chk("abort_ready", 32'(bus.llr_ready), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    cyc(2);

    // Restart from address 0 with fresh lanes; start while busy is ignored.
    do_start();
    push(8'd0, 18'h16554);
    push(8'd1, 18'h19617);
    push(8'd2, 18'h1C6DA);
    push(8'd3, 18'h1F79D);
    send(8'd20, 0);
    start = 1'b1;
    send(8'd21, 0);
    start = 1'b0;
    for (int i = 22; i <= 31; i++) send(8'(i), 0);
    tail_check();

    // Async reset while a write strobe is on the bus.
    cyc(1);
    do_start();
    mon_en = 1'b0;
    for (int i = 1; i <= 3; i++) send(8'(i), 0);
    chk("pre_rst_cs", 32'(bus.ram_cs), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_cs", 32'(bus.ram_cs), 32'd0);
    chk("arst_we", 32'(bus.ram_we), 32'd0);
    chk("arst_data", 32'(bus.ram_data), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(bus.llr_ready), 32'd0);
    cyc(1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;
    cyc(2);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_ready", 32'(bus.llr_ready), 32'd0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
